serial_add_sequencer: RTL and testbench

//  Bit-serial WIDTH-bit adder controller; sequences one shared 1-bit add cell
//  (two-level half-add: sum = x^y^c, carry = x&y | c&(x^y)) over the operand bits, LSB first.

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/serial_add_cell.sv | 18 +
 rtl/serial_add_sequencer.sv | 97 +++++++++
 tb/tb_serial_add_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type and counter-width helper for the bit-serial adder.
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

    function automatic int sa_cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    localparam int SA_DEF_WIDTH = 8;
    localparam int SA_CNT_W = sa_cnt_w(SA_DEF_WIDTH);

endpackage

// File: rtl/serial_add_cell.sv
// serial_add_cell: combinational 1-bit full add built from two half-add stages.
module serial_add_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);

    logic p;
    logic g;

    assign p  = x ^ y;
    assign g  = x & y;
    assign s  = p ^ c;
    assign co = g | (p & c);

endmodule

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial WIDTH-bit adder, one bit per clock, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = sa_cnt_w(WIDTH);

    sa_state_t        state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] sh;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             s;
    logic             co;

    serial_add_cell u_cell (
        .x (ra[cnt]),
        .y (rb[cnt]),
        .c (carry),
        .s (s),
        .co(co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            sh    <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sh    <= {s, sh[WIDTH-1:1]};
                    carry <= co;
                    cnt   <= cnt + 1'b1;
                    // sum/cout are only written here so partial results never show
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum   <= {s, sh[WIDTH-1:1]};
                        cout  <= co;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= carry ^ co;
`endif
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: directed and randomised checks of the WIDTH=8 serial adder.
// Define SERIAL_ADD_OVF_EN to also check ovf.
module tb_serial_add_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_add_sequencer #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic ci, output int lat);
        logic [7:0] held;
        logic       moved;
        @(negedge clk);
        a = x; b = y; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        held  = sum;
        moved = 1'b0;
        lat   = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (!done && sum !== held) moved = 1'b1;
        end
        chk("latency", 32'(lat), 32'd8);
        chk("no_partial_sum", 32'(moved), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic after_done();
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cyc, ndone, c1, c2;
        logic [7:0] s1, s2;
        logic [8:0] ref_v;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf",  32'(ovf),  32'd0);
`endif
        @(negedge clk) rst = 1'b0;

        do_op(8'h0F, 8'h01, 1'b0, lat);
        chk("t1_sum",  32'(sum),  32'h10);
        chk("t1_cout", 32'(cout), 32'd0);
        after_done();

        do_op(8'hFF, 8'h01, 1'b0, lat);
        chk("t2_sum",  32'(sum),  32'h00);
        chk("t2_cout", 32'(cout), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
        chk("t2_ovf",  32'(ovf),  32'd0);
`endif
        after_done();
        do_op(8'h00, 8'h00, 1'b1, lat);
        chk("t2b_sum",  32'(sum),  32'h01);
        chk("t2b_cout", 32'(cout), 32'd0);
        after_done();

        do_op(8'h7F, 8'h01, 1'b0, lat);
        chk("t3_sum",  32'(sum),  32'h80);
        chk("t3_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("t3_ovf",  32'(ovf),  32'd1);
`endif
        after_done();

        // start held: accepts at edges 1 and 11, dones at 9 and 19
        @(negedge clk);
        a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
        ndone = 0; c1 = 0; c2 = 0; s1 = '0; s2 = '0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 3) begin a = 8'h50; b = 8'h05; end
            if (done) begin
                ndone++;
                if (ndone == 1) begin c1 = cyc; s1 = sum; end
                else begin c2 = cyc; s2 = sum; end
            end
        end
        start = 1'b0;
        chk("t4_ndone", 32'(ndone), 32'd2);
        chk("t4_c1",    32'(c1),    32'd9);
        chk("t4_s1",    32'(s1),    32'h07);
        chk("t4_c2",    32'(c2),    32'd19);
        chk("t4_s2",    32'(s2),    32'h55);
        repeat (2) @(posedge clk);

        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_sum",  32'(sum),  32'd0);
        chk("t5_cout", 32'(cout), 32'd0);
        @(negedge clk) rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("t5_no_done", 32'(ndone), 32'd0);
        do_op(8'h11, 8'h22, 1'b0, lat);
        chk("t5_resume_sum", 32'(sum), 32'h33);
        after_done();

        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = 8'(i * 37); b = ~a; cin = i[0];
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("t6_no_activity", 32'(ndone), 32'd0);
        chk("t6_sum",  32'(sum),  32'h33);
        chk("t6_cout", 32'(cout), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] x, y;
            logic       ci;
            x = 8'($urandom);
            y = 8'($urandom);
            ci = 1'($urandom);
            ref_v = {1'b0, x} + {1'b0, y} + {8'd0, ci};
            do_op(x, y, ci, lat);
            chk("rnd_sum",  32'(sum),  32'(ref_v[7:0]));
            chk("rnd_cout", 32'(cout), 32'(ref_v[8]));
`ifdef SERIAL_ADD_OVF_EN
            chk("rnd_ovf", 32'(ovf), 32'((x[7] == y[7]) && (ref_v[7] != x[7])));
`endif
            after_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
